// File: rtl/bcd_sub_seq_pkg.sv
// bcd_sub_seq_pkg: shared constants for the digit-serial BCD subtractor
//   IDLE/SUB/COMP/DONE  FSM state encodings
//   DIGIT_W             bits per packed BCD digit
//   DIGIT_MAX           largest legal BCD digit value
//   DIGITS_DEF          default operand length in digits
package bcd_sub_seq_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SUB  = 2'd1;
   localparam logic [1:0] COMP = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   localparam int DIGIT_W = 4;
   localparam logic [3:0] DIGIT_MAX = 4'd9;
   localparam int DIGITS_DEF = 4;
endpackage

// File: rtl/bcd_sub_seq_digit.sv
// bcd_digit_sub: one-digit BCD subtract with borrow, d = x - y - bin (mod 10)
//   x, y  input  BCD digits (0-9)
//   bin   input  borrow in
//   d     output result digit (0-9)
//   bout  output borrow out
module bcd_digit_sub
   import bcd_sub_seq_pkg::*;
(
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               bin,
   output logic [DIGIT_W-1:0] d,
   output logic               bout
);
   // 5-bit raw difference spans -10..9; its MSB is the sign, hence the borrow
   logic [DIGIT_W:0] t;
   always_comb begin
      t    = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bin};
      bout = t[DIGIT_W];
      d    = bout ? t[DIGIT_W-1:0] + 4'd10 : t[DIGIT_W-1:0];
   end
endmodule

// File: rtl/bcd_sub_seq.sv
// bcd_sub_seq: digit-serial packed-BCD |a - b| with sign, one digit per clock
//   clk, rst  clock, asynchronous active-high reset
//   start     launch request, honoured only in IDLE
//   a, b      packed BCD operands, digit 0 in bits [3:0]
//   busy      high while subtracting or complementing
//   done      one-cycle completion pulse
//   diff      magnitude |a - b| in packed BCD
//   neg       set when a < b
//   err       set when an operand digit exceeds 9
module bcd_sub_seq
   import bcd_sub_seq_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DIGIT_W*DIGITS-1:0] a,
   input  logic [DIGIT_W*DIGITS-1:0] b,
   output logic                      busy,
   output logic                      done,
   output logic [DIGIT_W*DIGITS-1:0] diff,
   output logic                      neg,
   output logic                      err
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   logic [1:0]                state;
   logic [IW-1:0]             idx;
   logic                      borrow;
   logic [DIGIT_W*DIGITS-1:0] ra;
   logic [DIGIT_W*DIGITS-1:0] rb;
   logic [DIGIT_W-1:0]        x;
   logic [DIGIT_W-1:0]        y;
   logic [DIGIT_W-1:0]        d;
   logic                      bout;
   logic                      valid;
   logic                      last;
   always_comb begin
      valid = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (a[DIGIT_W*i +: DIGIT_W] > DIGIT_MAX || b[DIGIT_W*i +: DIGIT_W] > DIGIT_MAX) valid = 1'b0;
   end
   // COMP reuses the same digit subtractor as 0 - diff_i, giving 10^DIGITS - r
   assign x    = state == COMP ? '0 : ra[DIGIT_W*idx +: DIGIT_W];
   assign y    = state == COMP ? diff[DIGIT_W*idx +: DIGIT_W] : rb[DIGIT_W*idx +: DIGIT_W];
   assign last = idx == IW'(DIGITS - 1);
   assign busy = state == SUB || state == COMP;
   assign done = state == DONE;
   bcd_digit_sub u_digit (
      .x    (x),
      .y    (y),
      .bin  (borrow),
      .d    (d),
      .bout (bout)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         borrow <= 1'b0;
         ra     <= '0;
         rb     <= '0;
         diff   <= '0;
         neg    <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               diff <= '0;
               neg  <= 1'b0;
               err  <= !valid;
               if (valid) begin
                  ra     <= a;
                  rb     <= b;
                  borrow <= 1'b0;
                  idx    <= '0;
                  state  <= SUB;
               end else state <= DONE;
            end
            SUB, COMP: begin
               diff[DIGIT_W*idx +: DIGIT_W] <= d;
               borrow <= bout;
               idx    <= idx + 1'b1;
               if (last) begin
                  // a final borrow out of SUB means a < b: complement the residue
                  idx    <= '0;
                  borrow <= 1'b0;
                  if (state == SUB) neg <= bout;
                  state  <= state == SUB && bout ? COMP : DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_sub_seq.sv
// tb_bcd_sub_seq: self-checking bench for bcd_sub_seq with DIGITS=4
module tb_bcd_sub_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy, done, neg, err;
   logic [15:0] diff;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bcd_sub_seq #(.DIGITS(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .neg   (neg),
      .err   (err)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] d;
      logic        n;
      logic        e;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit bcd_ok(input logic [15:0] v);
      for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int bcd2int(input logic [15:0] v);
      int r = 0;
      for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input int v);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // plain-integer reference: |a-b|, sign, and cycle cost
   function automatic vec_t model(input logic [15:0] ta, input logic [15:0] tb);
      vec_t v;
      int m;
      v.a = ta;
      v.b = tb;
      if (!bcd_ok(ta) || !bcd_ok(tb)) begin
         v.d = '0; v.n = 1'b0; v.e = 1'b1; v.lat = 0;
      end else begin
         m = bcd2int(ta) - bcd2int(tb);
         v.n = m < 0;
         v.d = int2bcd(m < 0 ? -m : m);
         v.e = 1'b0;
         v.lat = m < 0 ? 8 : 4;
      end
      return v;
   endfunction

   function automatic logic [15:0] rand_bcd(input bit allow_bad);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      if (allow_bad && $urandom_range(0, 7) == 0) r[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      return r;
   endfunction

   task automatic run_and_check(input string nm, input vec_t v);
      int lat = 0;
      int bcnt = 0;
      logic [15:0] rd;
      logic rn, re;
      @(negedge clk);
      a = v.a; b = v.b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      a = ~v.a; b = ~v.b;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         @(posedge clk);
         #1 lat++;
      end
      rd = diff; rn = neg; re = err;
      chk({nm, " lat"}, lat, v.lat);
      chk({nm, " busy"}, bcnt, v.lat);
      chk({nm, " diff"}, rd, v.d);
      chk({nm, " neg"}, rn, v.n);
      chk({nm, " err"}, re, v.e);
      @(posedge clk);
      #1 chk({nm, " pulse"}, {done, diff, neg, err}, {1'b0, v.d, v.n, v.e});
   endtask

   initial begin
      vec_t tbl[8];
      vec_t v;
      int lat;
      logic seen;
      tbl[0] = '{16'h1234, 16'h0567, 16'h0667, 1'b0, 1'b0, 4};
      tbl[1] = '{16'h0100, 16'h0250, 16'h0150, 1'b1, 1'b0, 8};
      tbl[2] = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 8};
      tbl[3] = '{16'h4321, 16'h4321, 16'h0000, 1'b0, 1'b0, 4};
      tbl[4] = '{16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 0};
      tbl[5] = '{16'h0009, 16'h0003, 16'h0006, 1'b0, 1'b0, 4};
      tbl[6] = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 4};
      tbl[7] = '{16'h0001, 16'h0002, 16'h0001, 1'b1, 1'b0, 8};
      #2 chk("reset outputs", {busy, done, diff, neg, err}, '0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) run_and_check($sformatf("vec%0d", i), tbl[i]);
      for (int i = 0; i < 40; i++) run_and_check($sformatf("rnd%0d", i), model(rand_bcd(1'b1), rand_bcd(1'b1)));
      start = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         v = model(rand_bcd(1'b0), rand_bcd(1'b0));
         a = v.a; b = v.b;
         lat = 0;
         seen = 1'b0;
         while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            seen = done;
            if (seen) begin
               chk($sformatf("hold%0d diff", k), diff, v.d);
               chk($sformatf("hold%0d neg", k), neg, v.n);
               chk($sformatf("hold%0d err", k), err, v.e);
            end
            a = 16'($urandom); b = 16'($urandom);
         end
         chk($sformatf("hold%0d lat", k), lat, v.lat + 1);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      a = 16'h1234; b = 16'h0567; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("async reset", {busy, done, diff, neg, err}, '0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | done;
      end
      chk("no done after reset", seen, 1'b0);
      run_and_check("post reset", '{16'h0009, 16'h0003, 16'h0006, 1'b0, 1'b0, 4});
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bcd_sub_seq.md
# bcd_sub_seq

Digit-serial, multi-digit packed-BCD subtractor that computes |a − b| and its sign, one BCD digit per clock.
- It is the inverse operation to the team's combinational 4-bit BCD adder and sits beside it in the decimal arithmetic datapath.
- A start/busy/done handshake lets a controller launch one subtraction at a time.
- Negative differences are returned as magnitude plus sign, using a second ten's-complement pass.

## Interface
Parameters:
- DIGITS, 4, number of packed BCD digits per operand (≥1)

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- a  input  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0]
- b  input  4*DIGITS  subtrahend, packed BCD
- busy  output  1  high in SUB and COMP states
- done  output  1  one-cycle pulse, high only in DONE state
- diff  output  4*DIGITS  magnitude |a − b|, packed BCD
- neg  output  1  1 when a < b
- err  output  1  1 when any input digit of a or b exceeds 9

## Operation
- States: IDLE, SUB, COMP, DONE.
- IDLE, start=1, all digits valid (≤9):
  - latch a and b into internal registers;
  - clear diff, neg and err;
  - set borrow=0 and digit index=0;
  - go to SUB.
- IDLE, start=1, any digit >9: set diff=0, neg=0, err=1; go to DONE.
- SUB (one edge per digit, LSB first):
  - d = a_i − b_i − borrow;
  - if d<0, write d+10 and set borrow=1; else write d and set borrow=0;
  - store the result into diff digit i.
- After the digit DIGITS−1 edge in SUB:
  - final borrow=0: go to DONE;
  - final borrow=1: set neg=1, reset index and borrow to 0, go to COMP.
- COMP (one edge per digit, LSB first): diff_i ← 0 − diff_i − borrow, using the same digit rule. This yields 10^DIGITS − r, the magnitude. After digit DIGITS−1, go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- start is ignored in SUB, COMP and DONE. It is not queued.
- diff, neg and err hold their values from DONE until the next accepted start.
- a and b may change freely after the accepting edge.
- Width rule: every stored digit is always in 0–9. The intermediate digit difference needs 5 bits (signed range −10…9).

## Timing
- Reset (asynchronous, any state, including mid-SUB or mid-COMP):
  - state=IDLE, busy=0, done=0, diff=0, neg=0, err=0;
  - borrow, index and operand registers cleared;
  - the operation in progress is abandoned, with no done pulse.
- Edge 0 = the edge that samples start=1 in IDLE.
- Result a ≥ b: busy high after edges 0…DIGITS−1; done high in the cycle after edge DIGITS.
- Result a < b: busy high through edge 2·DIGITS−1; done high in the cycle after edge 2·DIGITS.
- Invalid input: done high in the cycle after edge 0; busy never asserts.
- diff, neg and err are final and stable whenever done=1.
- Earliest next accepted start: the edge after DONE, i.e. the first IDLE cycle.
- Throughput: one operation per DIGITS+2 cycles (a ≥ b) or 2·DIGITS+2 cycles (a < b).

## Structure
- Shared package:
  - state encoding constants IDLE/SUB/COMP/DONE;
  - BCD digit width (4);
  - the digit-valid limit (9);
  - the DIGITS default.
- One sub-module: bcd_digit_sub (inputs x[3:0], y[3:0], bin; outputs d[3:0], bout). It is purely combinational and shared by the SUB and COMP passes through an operand mux (COMP drives x=0, y=diff_i).
- The top level holds the FSM, the digit index counter, the borrow flop, the operand registers, and the diff shift/indexed write.

## Test plan
All cases use DIGITS=4.
- a=16'h1234, b=16'h0567, start for one cycle → busy for 4 cycles, done in the cycle after edge 4; diff=16'h0667, neg=0, err=0.
- a=16'h0100, b=16'h0250 → done in the cycle after edge 8; diff=16'h0150, neg=1.
- a=16'h0000, b=16'h9999 → diff=16'h9999, neg=1. Also a=16'h4321, b=16'h4321 → diff=16'h0000, neg=0 and no COMP pass (done after edge 4).
- a=16'h12A4, b=16'h0001 → err=1, diff=0, neg=0, done in the cycle after edge 0, busy never high. A subsequent valid start clears err.
- Hold start=1 continuously with changing a/b → only IDLE-cycle samples are accepted; each result matches the operands latched at its accepting edge.
- Assert rst during the 2nd SUB cycle, asynchronous to clk → all outputs 0 immediately, no done pulse. The next start with a=16'h0009, b=16'h0003 → diff=16'h0006.
